// File: rtl/memory_stage.sv
// Pipeline memory stage: issues one data-bus access per load/store, holds it
// while the bus is busy, and aligns/extends load data into the writeback value.
module memory_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [63:0] in_pc,
  input  logic [63:0] in_alu_out,
  input  logic [63:0] in_wdata,
  input  logic        in_memread,
  input  logic        in_memwrite,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [4:0]  in_dst,
  input  logic        hold,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [1:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data,
  output logic        m_wait,
  output logic        out_valid,
  output logic [63:0] out_result,
  output logic [4:0]  out_dst,
  output logic [63:0] out_pc,
  output logic        out_misalign
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [63:0] r_cap_data;

  logic        w_memop;
  logic [2:0]  w_off;
  logic        w_misalign;
  logic        w_dreq_valid;
  logic [7:0]  w_mask;
  logic [63:0] w_load_raw;
  logic [63:0] w_shifted;
  logic [63:0] w_extracted;

  assign w_memop = in_valid & (in_memread | in_memwrite);
  assign w_off   = in_alu_out[2:0];

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_misalign = 1'b0;
    w_mask     = 8'hFF;
    case (in_size)
      2'd0: begin w_misalign = 1'b0;          w_mask = 8'h01; end
      2'd1: begin w_misalign = w_off[0];      w_mask = 8'h03; end
      2'd2: begin w_misalign = |w_off[1:0];   w_mask = 8'h0F; end
      default: begin w_misalign = |w_off;     w_mask = 8'hFF; end
    endcase
  end

  // Reset gates the request combinationally so the bus sees nothing mid-reset.
  assign w_dreq_valid = ~reset &
                        (((r_state == S_IDLE) & w_memop & ~w_misalign) |
                         (r_state == S_WAIT));

  assign dreq_valid  = w_dreq_valid;
  assign dreq_addr   = in_alu_out;
  assign dreq_size   = in_size;
  assign dreq_data   = in_wdata << {w_off, 3'b000};
  assign dreq_strobe = in_memwrite ? (w_mask << w_off) : 8'h00;
  assign m_wait      = w_dreq_valid & ~dresp_data_ok;

  assign w_load_raw = (r_state == S_DONE) ? r_cap_data : dresp_data;
  assign w_shifted  = w_load_raw >> {w_off, 3'b000};

  always_comb begin
    w_extracted = w_shifted;
    case (in_size)
      2'd0: w_extracted = in_unsigned ? {56'd0, w_shifted[7:0]}
                                      : {{56{w_shifted[7]}}, w_shifted[7:0]};
      2'd1: w_extracted = in_unsigned ? {48'd0, w_shifted[15:0]}
                                      : {{48{w_shifted[15]}}, w_shifted[15:0]};
      2'd2: w_extracted = in_unsigned ? {32'd0, w_shifted[31:0]}
                                      : {{32{w_shifted[31]}}, w_shifted[31:0]};
      default: w_extracted = w_shifted;
    endcase
  end

  always_comb begin
    out_result = in_alu_out;
    if (w_memop & w_misalign)
      out_result = 64'd0;
    else if (in_valid & in_memread)
      out_result = w_extracted;
  end

  assign out_valid    = in_valid & ~reset;
  assign out_misalign = ~reset & w_memop & w_misalign;
  assign out_dst      = in_dst;
  assign out_pc       = in_pc;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      r_state    <= S_IDLE;
      r_cap_data <= 64'd0;
    end else begin
      if (w_dreq_valid & dresp_data_ok)
        r_cap_data <= dresp_data;
      case (r_state)
        S_IDLE: begin
          if (w_dreq_valid) begin
            if (!dresp_data_ok)  r_state <= S_WAIT;
            else if (hold)       r_state <= S_DONE;
          end
        end
        S_WAIT: begin
          if (dresp_data_ok) r_state <= hold ? S_DONE : S_IDLE;
        end
        S_DONE: begin
          if (!hold) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: inputs change 1 time unit after the rising
// edge, outputs are compared mid-cycle against hand-computed values.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [63:0] in_pc;
  logic [63:0] in_alu_out;
  logic [63:0] in_wdata;
  logic        in_memread;
  logic        in_memwrite;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [4:0]  in_dst;
  logic        hold;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        m_wait;
  logic        out_valid;
  logic [63:0] out_result;
  logic [4:0]  out_dst;
  logic [63:0] out_pc;
  logic        out_misalign;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
    .in_alu_out(in_alu_out), .in_wdata(in_wdata), .in_memread(in_memread),
    .in_memwrite(in_memwrite), .in_size(in_size), .in_unsigned(in_unsigned),
    .in_dst(in_dst), .hold(hold), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
    .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data), .m_wait(m_wait),
    .out_valid(out_valid), .out_result(out_result), .out_dst(out_dst),
    .out_pc(out_pc), .out_misalign(out_misalign)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before comparing.
  task automatic settle();
    #3;
  endtask

  task automatic set_op(input logic v, input logic rd, input logic wr,
                        input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wd);
    in_valid = v; in_memread = rd; in_memwrite = wr; in_size = sz;
    in_unsigned = uns; in_alu_out = addr; in_wdata = wd;
  endtask

  task automatic set_bus(input logic ok, input logic [63:0] d);
    dresp_data_ok = ok; dresp_data = d;
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0;
    in_pc = 64'h8000_0040; in_dst = 5'd7;
    set_bus(1'b0, 64'd0);
    // Misaligned lw held during reset: every status output must stay low.
    set_op(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 64'h3002, 64'd0);
    settle();
    check("rst_dreq_valid", dreq_valid, 0);
    check("rst_m_wait", m_wait, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_misalign", out_misalign, 0);
    next_cycle();
    next_cycle();

    // lb 0x1005, response in cycle 3.
    reset = 1'b0;
    set_op(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 64'h1005, 64'd0);
    settle();
    check("lb_c0_dreq_valid", dreq_valid, 1);
    check("lb_c0_m_wait", m_wait, 1);
    check("lb_strobe", dreq_strobe, 0);
    check("lb_addr", dreq_addr, 64'h1005);
    check("lb_pc", out_pc, 64'h8000_0040);
    check("lb_dst", out_dst, 7);
    next_cycle(); settle();
    check("lb_c1_m_wait", m_wait, 1);
    next_cycle(); settle();
    check("lb_c2_m_wait", m_wait, 1);
    check("lb_c2_dreq_valid", dreq_valid, 1);
    next_cycle();
    set_bus(1'b1, 64'h0000_8000_0000_0000);
    settle();
    check("lb_c3_m_wait", m_wait, 0);
    check("lb_c3_result", out_result, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_c3_out_valid", out_valid, 1);

    // sh 0x2006 issued the very next cycle, response same cycle.
    next_cycle();
    set_op(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 64'h2006, 64'hBEEF);
    set_bus(1'b1, 64'd0);
    settle();
    check("sh_dreq_valid", dreq_valid, 1);
    check("sh_data", dreq_data, 64'hBEEF_0000_0000_0000);
    check("sh_strobe", dreq_strobe, 8'hC0);
    check("sh_m_wait", m_wait, 0);
    check("sh_result", out_result, 64'h2006);
    next_cycle();
    set_op(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
    set_bus(1'b0, 64'd0);
    settle();
    check("sh_single_request", dreq_valid, 0);

    // Misaligned lw 0x3002.
    next_cycle();
    set_op(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 64'h3002, 64'd0);
    settle();
    check("lw_mis_dreq_valid", dreq_valid, 0);
    check("lw_mis_m_wait", m_wait, 0);
    check("lw_mis_flag", out_misalign, 1);
    check("lw_mis_result", out_result, 0);

    // ld 0x4000 with hold for 4 cycles, response in cycle 1.
    next_cycle();
    hold = 1'b1;
    set_op(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 64'h4000, 64'd0);
    settle();
    check("ld_c0_dreq_valid", dreq_valid, 1);
    check("ld_c0_misalign", out_misalign, 0);
    next_cycle();
    set_bus(1'b1, 64'h1122_3344_5566_7788);
    settle();
    check("ld_c1_m_wait", m_wait, 0);
    check("ld_c1_result", out_result, 64'h1122_3344_5566_7788);
    next_cycle();
    set_bus(1'b0, 64'hDEAD_DEAD_DEAD_DEAD);
    settle();
    check("ld_c2_dreq_valid", dreq_valid, 0);
    check("ld_c2_m_wait", m_wait, 0);
    check("ld_c2_result", out_result, 64'h1122_3344_5566_7788);
    next_cycle(); settle();
    check("ld_c3_dreq_valid", dreq_valid, 0);
    check("ld_c3_result", out_result, 64'h1122_3344_5566_7788);
    next_cycle();
    hold = 1'b0;
    settle();
    check("ld_c4_dreq_valid", dreq_valid, 0);
    check("ld_c4_result", out_result, 64'h1122_3344_5566_7788);

    // lh at offset 2, signed; response same cycle.
    next_cycle();
    set_op(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 64'h000A, 64'd0);
    set_bus(1'b1, 64'h0000_0000_8001_0000);
    settle();
    check("lh_result", out_result, 64'hFFFF_FFFF_FFFF_8001);

    // lwu at offset 4, zero-extended.
    next_cycle();
    set_op(1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 64'h0004, 64'd0);
    set_bus(1'b1, 64'hF000_0001_0000_0000);
    settle();
    check("lwu_result", out_result, 64'h0000_0000_F000_0001);

    // lhu 0x10: reset asserted in the second WAIT cycle.
    next_cycle();
    set_op(1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 64'h0010, 64'd0);
    set_bus(1'b0, 64'd0);
    settle();
    check("lhu_c0_dreq_valid", dreq_valid, 1);
    next_cycle(); settle();
    check("lhu_c1_m_wait", m_wait, 1);
    next_cycle();
    reset = 1'b1;
    settle();
    check("lhu_rst_dreq_valid", dreq_valid, 0);
    check("lhu_rst_m_wait", m_wait, 0);
    check("lhu_rst_out_valid", out_valid, 0);
    next_cycle();
    reset = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
    set_bus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    settle();
    check("late_ok_dreq_valid", dreq_valid, 0);
    check("late_ok_m_wait", m_wait, 0);
    check("late_ok_out_valid", out_valid, 0);

    // add after the abandoned access: pure pass-through.
    next_cycle();
    set_bus(1'b0, 64'd0);
    set_op(1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 64'h1234, 64'h5555);
    settle();
    check("add_result", out_result, 64'h1234);
    check("add_dreq_valid", dreq_valid, 0);
    check("add_m_wait", m_wait, 0);
    check("add_out_valid", out_valid, 1);
    check("add_misalign", out_misalign, 0);

    next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
